vliw_issue_ctrl: RTL
====================

Name: vliw_issue_ctrl

Overview:
Issue scheduler in front of vliw_top. Accepts VLIW bundles (64-bit word + 192-bit immediate data) over a valid/ready handshake. Tracks in-flight register writes in a 16-entry scoreboard and stalls any bundle with RAW/WAW hazards. Resolves intra-bundle destination conflicts, then drives one registered bundle per cycle into vliw_top; when nothing is issued it drives a NOP bundle.

Parameters:
WB_LAT, 3, cycles a destination register stays busy after its writer issues (1..7)
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  bundle available
in_ready  output  1  bundle accepted this cycle when in_valid && in_ready
in_word  input  64  bundle word: slot1 [58:55] op, [53:50] src1, [48:45] src2, [43:40] dest; slot2 [38:35]/[33:30]/[28:25]/[23:20]; slot3 [18:15]/[13:10]/[8:5]/[3:0]
in_data  input  192  immediate data: slot1 [191:128], slot2 [127:64], slot3 [63:0]
halt  input  1  freeze issue; scoreboard keeps draining
issue_word  output  64  registered bundle to vliw_top
issue_data  output  192  registered data to vliw_top
issue_valid  output  1  issue_word holds a real bundle this cycle
conflict  output  1  one-cycle pulse: slot(s) converted to NOP due to duplicate dest
busy_regs  output  16  scoreboard busy vector, bit n = reg n
state  output  2  00 IDLE, 01 ISSUE, 10 STALL, 11 HALTED
stall_count  output  STALL_CNT_W  cycles with in_valid=1 && in_ready=0, saturating

Behaviour:
- Opcode classes: 0000 NOP (no reads, no write); 0100 LOAD (writes dest); 0110 READ (reads src1); every other opcode ALU (reads src1, src2, writes dest).
- Scoreboard: per-register down-counter cnt[n], width 3. busy[n] = (cnt[n] != 0). Each cycle nonzero counters decrement by 1; on accept, cnt[dest] <= WB_LAT for every writing slot (load overrides decrement).
- Hazard (combinational on in_word): any slot reading a busy src, or any writing slot with busy dest.
- in_ready = reset && !halt && !hazard. Independent of in_valid.
- Intra-bundle duplicate dest among writing slots: lowest-numbered slot wins (slot1 > slot2 > slot3); losers rewritten to opcode 0000 with src/dest/data zeroed; conflict pulses the cycle after accept, aligned with issue_valid. Intra-bundle read-after-write is not a hazard (all slots read pre-bundle values).
- Issue: on accept, issue_word/issue_data load the (possibly NOP-patched) bundle next cycle, issue_valid=1. Reserved bits [63:59],[54],[49],[44],[39],[34],[29],[24],[19],[14],[9],[4] forced to 0. Otherwise issue_word=0, issue_data=0, issue_valid=0. Latency in_valid&&in_ready -> issue_valid: 1 cycle. Back-to-back accepts sustain one bundle/cycle.
- State (registered, next cycle): HALTED if halt; else ISSUE if accept; else STALL if in_valid && hazard; else IDLE. HALTED exits when halt deasserts.
- stall_count increments on in_valid && !in_ready, including halt-caused stalls; holds at all-ones.
- halt asserted while an issue is in flight: issued bundle still appears; no new accept.
- Reset (reset=0 at clock edge): cnt all 0, busy_regs=0, issue_word=0, issue_data=0, issue_valid=0, conflict=0, state=IDLE, stall_count=0, in_ready=0. Reset mid-stall discards pending hazard status; bundle must be re-presented.

Test Plan:
- Reset held 2 cycles -> all outputs 0, state=00; release, in_valid=0 -> issue_word=0, state stays 00.
- LOAD 123456789abcdef0->r0, 1000000000000001->r1, 0111111111111110->r2 in one bundle -> issue_valid next cycle, issue_data[191:128]=123456789abcdef0, busy_regs=0x0007 for 3 cycles then 0.
- Next cycle present sub r0,r1->r11 (WB_LAT=3) -> in_ready=0 for 3 cycles, state=10, stall_count=3, then accepted; issue_word[38:35]=0010.
- Bundle LOAD r5 in slot1 and slot3 -> slot3 issued as opcode 0000, data[63:0]=0, conflict=1 one cycle, busy_regs=0x0020.
- Independent bundles (loads r3/r4/r5 then r6/r7/r8) on consecutive cycles -> two consecutive issue_valid=1, no stall.
- halt=1 with valid hazard-free bundle -> in_ready=0, state=11, stall_count increments; busy counters still reach 0; halt=0 -> accept next cycle.

Source files
------------

// File: rtl/vliw_issue_ctrl.sv
// Issue scheduler for vliw_top: scoreboards in-flight register writes, stalls hazarded bundles,
// resolves duplicate destinations inside a bundle, and registers one bundle per cycle out.
module vliw_issue_ctrl #(
    parameter int unsigned WB_LAT      = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_word,
    input  logic [191:0]           in_data,
    input  logic                   halt,
    output logic [63:0]            issue_word,
    output logic [191:0]           issue_data,
    output logic                   issue_valid,
    output logic                   conflict,
    output logic [15:0]            busy_regs,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [1:0] StIdle   = 2'b00;
    localparam logic [1:0] StIssue  = 2'b01;
    localparam logic [1:0] StStall  = 2'b10;
    localparam logic [1:0] StHalted = 2'b11;

    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpLoad = 4'b0100;
    localparam logic [3:0] OpRead = 4'b0110;

    logic [3:0]  op   [3];
    logic [3:0]  src1 [3];
    logic [3:0]  src2 [3];
    logic [3:0]  dest [3];
    logic [63:0] dat  [3];
    logic        rd1  [3];
    logic        rd2  [3];
    logic        wr   [3];
    logic        lose [3];

    logic        hazard;
    logic        accept;
    logic [63:0] patched_word;
    logic [191:0] patched_data;
    logic [2:0]  cnt_q [16];
    logic [2:0]  cnt_d [16];

    // Reserved fields are dropped on the way out.
    logic unused_rsv;
    assign unused_rsv = ^{in_word[63:59], in_word[54], in_word[49], in_word[44], in_word[39],
                          in_word[34], in_word[29], in_word[24], in_word[19], in_word[14],
                          in_word[9], in_word[4]};

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            op[s]   = in_word[55-20*s +: 4];
            src1[s] = in_word[50-20*s +: 4];
            src2[s] = in_word[45-20*s +: 4];
            dest[s] = in_word[40-20*s +: 4];
            dat[s]  = in_data[128-64*s +: 64];
            rd1[s]  = (op[s] != OpNop) && (op[s] != OpLoad);
            rd2[s]  = rd1[s] && (op[s] != OpRead);
            wr[s]   = (op[s] != OpNop) && (op[s] != OpRead);
        end
    end

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            busy_regs[n] = (cnt_q[n] != 3'd0);
        end
    end

    // Slots read pre-bundle register values, so only the scoreboard can cause a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (rd1[s] && busy_regs[src1[s]]) hazard = 1'b1;
            if (rd2[s] && busy_regs[src2[s]]) hazard = 1'b1;
            if (wr[s] && busy_regs[dest[s]])  hazard = 1'b1;
        end
    end

    assign in_ready = reset && !halt && !hazard;
    assign accept   = in_valid && in_ready;

    // Lower-numbered slot keeps a duplicated destination.
    always_comb begin
        lose[0] = 1'b0;
        lose[1] = wr[1] && wr[0] && (dest[1] == dest[0]);
        lose[2] = wr[2] && ((wr[0] && (dest[2] == dest[0])) || (wr[1] && (dest[2] == dest[1])));
    end

    always_comb begin
        patched_word = '0;
        patched_data = '0;
        for (int s = 0; s < 3; s++) begin
            if (!lose[s]) begin
                patched_word[40-20*s +: 20] = {1'b0, op[s], 1'b0, src1[s], 1'b0, src2[s],
                                               1'b0, dest[s]};
                patched_data[128-64*s +: 64] = dat[s];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            cnt_d[n] = (cnt_q[n] != 3'd0) ? cnt_q[n] - 3'd1 : 3'd0;
        end
        if (accept) begin
            for (int s = 0; s < 3; s++) begin
                if (wr[s]) cnt_d[dest[s]] = 3'(WB_LAT);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int n = 0; n < 16; n++) cnt_q[n] <= 3'd0;
            issue_word  <= '0;
            issue_data  <= '0;
            issue_valid <= 1'b0;
            conflict    <= 1'b0;
            state       <= StIdle;
            stall_count <= '0;
        end else begin
            cnt_q       <= cnt_d;
            issue_word  <= accept ? patched_word : 64'd0;
            issue_data  <= accept ? patched_data : 192'd0;
            issue_valid <= accept;
            conflict    <= accept && (lose[1] || lose[2]);
            if (halt)                    state <= StHalted;
            else if (accept)             state <= StIssue;
            else if (in_valid && hazard) state <= StStall;
            else                         state <= StIdle;
            if (in_valid && !in_ready && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
        end
    end

endmodule
